// File: rtl/control_pipe_unit_if.sv
// control_pipe_unit_if: ID-stage decode inputs and per-stage control outputs between datapath and control unit.
interface control_pipe_unit_if #(
    parameter int ALUOP_W = 3,
    parameter int REG_AW  = 5
);
    logic [5:0]         opcode;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;
    logic               branch_taken;
    logic               id_ExtendSel;
    logic               id_Jump;
    logic               stall;
    logic               flush_ifid;
    logic               illegal_op;
    logic               ex_RegDst;
    logic               ex_ALUSrc;
    logic               ex_Branch;
    logic               ex_BranchNe;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic [REG_AW-1:0]  ex_dst;
    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic [REG_AW-1:0]  mem_dst;
    logic               wb_MemtoReg;
    logic               wb_RegWrite;
    logic [REG_AW-1:0]  wb_dst;

    modport master (
        output opcode, id_rs, id_rt, id_rd, branch_taken,
        input  id_ExtendSel, id_Jump, stall, flush_ifid, illegal_op,
        input  ex_RegDst, ex_ALUSrc, ex_Branch, ex_BranchNe, ex_ALUOp, ex_dst,
        input  mem_MemRead, mem_MemWrite, mem_dst, wb_MemtoReg, wb_RegWrite, wb_dst
    );

    modport slave (
        input  opcode, id_rs, id_rt, id_rd, branch_taken,
        output id_ExtendSel, id_Jump, stall, flush_ifid, illegal_op,
        output ex_RegDst, ex_ALUSrc, ex_Branch, ex_BranchNe, ex_ALUOp, ex_dst,
        output mem_MemRead, mem_MemWrite, mem_dst, wb_MemtoReg, wb_RegWrite, wb_dst
    );
endinterface

// File: rtl/control_pipe_unit.sv
// control_pipe_unit: MIPS 5-stage control decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and IF/ID flush generation.
module control_pipe_unit #(
    parameter int ALUOP_W        = 3,
    parameter int REG_AW         = 5,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    control_pipe_unit_if.slave bus
);
    localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_BNE = 6'd5, OP_ADDIU = 6'd9,
                           OP_ANDI = 6'd12, OP_ORI = 6'd13, OP_LW = 6'd35, OP_SW = 6'd43;

    logic [13:0] dec;
    logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, branch_ne, jump, ext, legal;
    logic [2:0] alu3;
    logic rt_src, hazard, stall, bubble;
    logic [REG_AW-1:0] dst;

    logic ex_reg_dst_q, ex_alu_src_q, ex_branch_q, ex_branch_ne_q;
    logic ex_mem_read_q, ex_mem_write_q, ex_mem_to_reg_q, ex_reg_write_q, illegal_q;
    logic [ALUOP_W-1:0] ex_alu_op_q;
    logic [REG_AW-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
    logic mem_mem_read_q, mem_mem_write_q, mem_mem_to_reg_q, mem_reg_write_q, wb_mem_to_reg_q, wb_reg_write_q;

    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,Jump}, ALUOp, ExtendSel, legal
    always_comb begin
        dec = '0;
        case (bus.opcode)
            OP_R:     dec = {9'b100100000, 3'b010, 2'b01};
            OP_ADDIU: dec = {9'b010100000, 3'b000, 2'b11};
            OP_ANDI:  dec = {9'b010100000, 3'b011, 2'b01};
            OP_ORI:   dec = {9'b010100000, 3'b100, 2'b01};
            OP_LW:    dec = {9'b011110000, 3'b000, 2'b11};
            OP_SW:    dec = {9'b010001000, 3'b000, 2'b11};
            OP_BEQ:   dec = {9'b000000100, 3'b001, 2'b11};
            OP_BNE:   dec = {9'b000000110, 3'b001, 2'b11};
            OP_J:     dec = {9'b000000001, 3'b000, 2'b01};
            default:  dec = '0;
        endcase
    end

    assign {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, branch_ne, jump, alu3, ext, legal} = dec;
    assign dst    = reg_dst ? bus.id_rd : bus.id_rt;
    assign rt_src = bus.opcode == OP_R || bus.opcode == OP_BEQ || bus.opcode == OP_BNE || bus.opcode == OP_SW;
    assign hazard = ex_mem_read_q && ex_dst_q != '0 &&
                    (ex_dst_q == bus.id_rs || (ex_dst_q == bus.id_rt && rt_src));
    // A taken branch squashes the ID instruction anyway, so it masks the stall.
    assign stall  = LOAD_USE_STALL && hazard && !bus.branch_taken;
    assign bubble = stall || bus.branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg_dst_q     <= 1'b0;
            ex_alu_src_q     <= 1'b0;
            ex_branch_q      <= 1'b0;
            ex_branch_ne_q   <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_alu_op_q      <= '0;
            ex_dst_q         <= '0;
            illegal_q        <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_dst_q        <= '0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_dst_q         <= '0;
        end else begin
            ex_reg_dst_q     <= !bubble && reg_dst;
            ex_alu_src_q     <= !bubble && alu_src;
            ex_branch_q      <= !bubble && branch;
            ex_branch_ne_q   <= !bubble && branch_ne;
            ex_mem_read_q    <= !bubble && mem_read;
            ex_mem_write_q   <= !bubble && mem_write;
            ex_mem_to_reg_q  <= !bubble && mem_to_reg;
            ex_reg_write_q   <= !bubble && reg_write;
            ex_alu_op_q      <= bubble ? '0 : ALUOP_W'(alu3);
            ex_dst_q         <= bubble ? '0 : dst;
            illegal_q        <= !bubble && !legal;
            mem_mem_read_q   <= ex_mem_read_q;
            mem_mem_write_q  <= ex_mem_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_reg_write_q  <= ex_reg_write_q;
            mem_dst_q        <= ex_dst_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_dst_q         <= mem_dst_q;
        end
    end

    assign bus.id_ExtendSel = ext;
    assign bus.id_Jump      = jump;
    assign bus.stall        = stall;
    assign bus.flush_ifid   = bus.branch_taken || (jump && !stall);
    assign bus.illegal_op   = illegal_q;
    assign bus.ex_RegDst    = ex_reg_dst_q;
    assign bus.ex_ALUSrc    = ex_alu_src_q;
    assign bus.ex_Branch    = ex_branch_q;
    assign bus.ex_BranchNe  = ex_branch_ne_q;
    assign bus.ex_ALUOp     = ex_alu_op_q;
    assign bus.ex_dst       = ex_dst_q;
    assign bus.mem_MemRead  = mem_mem_read_q;
    assign bus.mem_MemWrite = mem_mem_write_q;
    assign bus.mem_dst      = mem_dst_q;
    assign bus.wb_MemtoReg  = wb_mem_to_reg_q;
    assign bus.wb_RegWrite  = wb_reg_write_q;
    assign bus.wb_dst       = wb_dst_q;
endmodule
